router_out_sched: RTL
=====================

Name: router_out_sched

Overview:
- Scheduler that shares one 8-bit egress bus between the router's three output FIFOs (channels 0/1/2).
- Round-robin arbitration, granted at packet granularity: once a channel wins, its whole packet (header, payload, parity) is drained before the next grant.
- A watchdog aborts a stalled packet and soft-resets the offending FIFO.
- Sits downstream of the three router FIFOs, in place of per-port readers, where the ports merge onto one link.

Parameters:
- TIMEOUT, 30: consecutive cycles a granted FIFO may sit empty mid-packet before abort.
- TO_W, 5: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  3  per-channel FIFO empty flag.
- fifo_data  in  24  per-channel head word; channel i is bits [8i+7:8i]. FIFOs are show-ahead: the head is valid whenever the channel is not empty.
- read_enb  out  3  per-channel pop strobe; the FIFO pops its head at the clock edge.
- soft_reset  out  3  one-cycle pulse that flushes the FIFO of that channel.
- out_valid  out  1  egress word valid.
- out_data  out  8  egress word.
- out_ready  in  1  sink accepts the word this cycle.
- grant  out  3  one-hot owner of the bus, zero when idle.
- busy  out  1  high when not in IDLE.
- pkt_done  out  1  one-cycle pulse when a parity byte is accepted.
- pkt_abort  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Packet format
  - Header byte: length = data[7:2] (0..63), address = data[1:0].
  - Then `length` payload bytes, then 1 parity byte.
  - Total = length + 2 bytes.
- Reset values (while reset is high and the cycle after): state IDLE, rr_ptr = 2 so channel 0 has first priority. All outputs 0: read_enb, soft_reset, out_valid, grant, busy, pkt_done, pkt_abort; out_data = 0.
- States: IDLE, XFER, ABORT.
- IDLE
  - If any fifo_empty bit is 0, pick the first non-empty channel searching rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
  - Register the winner as sel, set grant, set hdr_pending = 1, go to XFER.
  - This costs one arbitration cycle; no words move while in IDLE.
- XFER
  - out_valid = !fifo_empty[sel]; out_data = fifo_data[sel]; read_enb[sel] = out_valid & out_ready.
  - out_valid and out_data are combinational from the FIFO head. out_data = 0 when out_valid = 0.
  - Header accepted: remaining = length + 1, hdr_pending = 0.
  - Payload or parity accepted: remaining decrements.
  - When remaining == 1 and the word is accepted: pkt_done pulses next cycle, rr_ptr = sel, go to IDLE (one bubble cycle between packets).
- Length 0: header, then parity only; the packet completes in 2 accepted words.
- out_ready low stalls the transfer with no state change. out_valid/out_data stay stable while out_ready is low and the FIFO is non-empty.
- Watchdog
  - In XFER: if fifo_empty[sel], wd increments; any accepted word clears wd.
  - Back-pressure with data present does not count.
  - When wd reaches TIMEOUT-1 while still empty, go to ABORT.
- ABORT (one cycle)
  - soft_reset[sel] = 1, pkt_abort = 1, rr_ptr = sel, grant = 0, then IDLE.
- Other FIFOs' empty transitions during XFER are ignored until IDLE.
- Reset mid-packet: immediate return to IDLE with reset values. No soft_reset is issued.
- Arithmetic: remaining is 7 bits (max 64); wd saturates at TIMEOUT-1.

Decomposition:
- Package router_pkg holds:
  - state encoding (IDLE/XFER/ABORT);
  - NUM_CH = 3;
  - header field positions LEN_MSB = 7, LEN_LSB = 2;
  - ADDR_W = 2.
- Sub-module router_rr_arbiter: 3-way combinational round-robin given the request vector and rr_ptr; outputs a one-hot winner and its index.
- Counters and the FSM live in router_out_sched.

Test Plan:
- Single packet: ch1 holds header 0x0D (len 3), payload A1 A2 A3, parity 5F, out_ready = 1 → grant = 010 one cycle after non-empty; 5 consecutive words 0D A1 A2 A3 5F; pkt_done 1 cycle after 5F; back to IDLE.
- Round-robin: all three FIFOs hold len-1 packets at reset release → grant order 001, 010, 100, 001; one IDLE cycle between each.
- Back-pressure: out_ready toggles 1,0,0,1 during payload → out_data held constant while low; no word lost or duplicated; wd stays 0.
- Zero-length: ch2 header 0x02, parity 0x02 → exactly 2 words; pkt_done pulses.
- Timeout: ch0 header len 5, only 2 payload bytes, then FIFO empty for 30 cycles → soft_reset = 001 and pkt_abort pulse on cycle 30; grant = 000; the next grant prefers ch1.
- Mid-packet reset: reset asserted after the 2nd word → next cycle all outputs 0, grant 000; after release, ch0 wins first.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router egress scheduler: state encoding,
// channel count and header field layout.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int NUM_CH  = 3;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;

  // Channel index successor, modulo NUM_CH.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_rr_arbiter.sv
// Three-way combinational round-robin: the channel after rr_ptr has the
// highest priority, rr_ptr itself the lowest.
module router_rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        rr_ptr,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [1:0]        gnt_idx,
  output logic              gnt_any
);

  logic [1:0] cand [NUM_CH];

  always_comb begin
    cand[0] = rr_next(rr_ptr);
    cand[1] = rr_next(cand[0]);
    cand[2] = rr_ptr;
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    // Walk from lowest to highest priority so the best candidate wins last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        gnt_idx = cand[i];
        gnt_any = 1'b1;
      end
    end
    gnt_onehot = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/router_out_sched.sv
// Egress scheduler: merges three show-ahead router FIFOs onto one 8-bit bus,
// granting whole packets round-robin, with a watchdog for stalled packets.
module router_out_sched
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   fifo_empty,
  input  logic [8*NUM_CH-1:0] fifo_data,
  output logic [NUM_CH-1:0]   read_enb,
  output logic [NUM_CH-1:0]   soft_reset,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic [NUM_CH-1:0]   grant,
  output logic                busy,
  output logic                pkt_done,
  output logic                pkt_abort
);

  // Handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; the owning FIFO is popped on that same edge.

  state_t            state;
  logic [1:0]        sel;
  logic [1:0]        rr_ptr;
  logic              hdr_pending;
  logic [6:0]        remaining;
  logic [TO_W-1:0]   wd;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] soft_reset_q;
  logic              pkt_done_q;
  logic              pkt_abort_q;

  logic [NUM_CH-1:0] arb_onehot;
  logic [1:0]        arb_idx;
  logic              arb_any;
  logic [NUM_CH-1:0] sel_onehot;
  logic              sel_empty;
  logic [7:0]        sel_data;
  logic              accept;

  router_rr_arbiter u_arb (
    .req        (~fifo_empty),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = 8'h00;
    case (sel)
      2'd0: begin sel_empty = fifo_empty[0]; sel_data = fifo_data[7:0];   end
      2'd1: begin sel_empty = fifo_empty[1]; sel_data = fifo_data[15:8];  end
      2'd2: begin sel_empty = fifo_empty[2]; sel_data = fifo_data[23:16]; end
      default: begin sel_empty = 1'b1; sel_data = 8'h00; end
    endcase
  end

  assign sel_onehot = NUM_CH'(1) << sel;

  // Egress path is a straight pass-through of the granted FIFO head.
  assign out_valid  = !reset && (state == XFER) && !sel_empty;
  assign out_data   = out_valid ? sel_data : 8'h00;
  assign accept     = out_valid && out_ready;
  assign read_enb   = accept ? sel_onehot : '0;

  assign grant      = reset ? '0 : grant_q;
  assign soft_reset = reset ? '0 : soft_reset_q;
  assign pkt_done   = !reset && pkt_done_q;
  assign pkt_abort  = !reset && pkt_abort_q;
  assign busy       = !reset && (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= 2'd0;
      rr_ptr       <= 2'd2;
      hdr_pending  <= 1'b0;
      remaining    <= 7'd0;
      wd           <= '0;
      grant_q      <= '0;
      soft_reset_q <= '0;
      pkt_done_q   <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      soft_reset_q <= '0;
      pkt_done_q   <= 1'b0;
      pkt_abort_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            sel         <= arb_idx;
            grant_q     <= arb_onehot;
            hdr_pending <= 1'b1;
            wd          <= '0;
            state       <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            wd <= '0;
            if (hdr_pending) begin
              remaining   <= {1'b0, sel_data[LEN_MSB:LEN_LSB]} + 7'd1;
              hdr_pending <= 1'b0;
            end else if (remaining == 7'd1) begin
              pkt_done_q <= 1'b1;
              rr_ptr     <= sel;
              grant_q    <= '0;
              state      <= IDLE;
            end else begin
              remaining <= remaining - 7'd1;
            end
          end else if (sel_empty) begin
            // Only starvation counts; back-pressure with data present does not.
            if (wd == TO_W'(TIMEOUT - 1)) begin
              soft_reset_q <= sel_onehot;
              pkt_abort_q  <= 1'b1;
              rr_ptr       <= sel;
              grant_q      <= '0;
              state        <= ABORT;
            end else begin
              wd <= wd + 1'b1;
            end
          end
        end
        ABORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
